// File: rtl/jtag_tap_ctrl_mc_if.sv
// Pad-side and chain-side signals of the parametrised JTAG TAP controller.
// master: pads/chains driving the TAP; slave: the TAP controller itself.
interface jtag_tap_ctrl_mc_if #(
    parameter int NUM_CHAINS = 3
);
    logic                  tms;
    logic                  tdi;
    logic                  tdo_pad_o;
    logic                  tdo_padoe_o;
    logic                  tdo_o;
    logic [NUM_CHAINS-1:0] chain_tdi_i;
    logic [NUM_CHAINS-1:0] chain_select_o;
    logic                  shift_dr_o;
    logic                  pause_dr_o;
    logic                  update_dr_o;
    logic                  capture_dr_o;
    logic                  tlr_o;

    modport master (
        output tms, tdi, chain_tdi_i,
        input  tdo_pad_o, tdo_padoe_o, tdo_o, chain_select_o,
        input  shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o, tlr_o
    );

    modport slave (
        input  tms, tdi, chain_tdi_i,
        output tdo_pad_o, tdo_padoe_o, tdo_o, chain_select_o,
        output shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o, tlr_o
    );
endinterface

// File: rtl/jtag_tap_ctrl_mc.sv
// IEEE 1149.1 TAP controller with parametrised IR and N decoded scan-chain selects.
// Define JTAG_IDCODE_EN to include the 32-bit IDCODE register (reset instruction IDCODE).
module jtag_tap_ctrl_mc #(
    parameter int          IR_WIDTH   = 4,
    parameter int          NUM_CHAINS = 3,
    parameter int          CHAIN_BASE = 2,
    parameter int          IDCODE_OP  = 1,
    parameter logic [31:0] IDCODE_VAL = 32'h149511C3
) (
    input  logic                tck,
    input  logic                trst,
    jtag_tap_ctrl_mc_if.slave   jif
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] BYPASS_OP = '1;
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_OP = IR_WIDTH'(IDCODE_OP);
`else
    localparam logic [IR_WIDTH-1:0] RESET_OP = BYPASS_OP;
`endif

    if (IR_WIDTH < 2 || IDCODE_VAL[0] != 1'b1 || NUM_CHAINS < 1 ||
        (IDCODE_OP >= CHAIN_BASE && IDCODE_OP < CHAIN_BASE + NUM_CHAINS)) begin : g_param_check
        $error("jtag_tap_ctrl_mc: illegal parameter combination");
    end

    tap_state_e            state_q, state_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
    logic                  bypass_q, bypass_d;
    logic                  tdo_q, tdo_d;
    logic                  tdo_pad_q, tdo_pad_d;
    logic                  tdo_padoe_q, tdo_padoe_d;
    logic [NUM_CHAINS-1:0] chain_sel;
    logic                  idcode_sel;
    logic                  idcode_lsb;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = jif.tms ? TLR    : RTI;
            RTI:     state_d = jif.tms ? SEL_DR : RTI;
            SEL_DR:  state_d = jif.tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = jif.tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = jif.tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = jif.tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = jif.tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = jif.tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = jif.tms ? SEL_DR : RTI;
            SEL_IR:  state_d = jif.tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = jif.tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = jif.tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = jif.tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = jif.tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = jif.tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = jif.tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Opcodes are compared by equality, so at most one chain select can be high.
    always_comb begin
        chain_sel  = '0;
        idcode_sel = 1'b0;
`ifdef JTAG_IDCODE_EN
        idcode_sel = (ir_q == IR_WIDTH'(IDCODE_OP));
`endif
        for (int k = 0; k < NUM_CHAINS; k++) begin
            if (ir_q == IR_WIDTH'(CHAIN_BASE + k) && ir_q != BYPASS_OP && !idcode_sel)
                chain_sel[k] = 1'b1;
        end
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        bypass_d   = bypass_q;
        tdo_d      = jif.tdi;
        case (state_q)
            CAP_IR:  ir_shift_d = IR_WIDTH'(1);
            SH_IR:   ir_shift_d = {jif.tdi, ir_shift_q[IR_WIDTH-1:1]};
            CAP_DR:  bypass_d   = 1'b0;
            SH_DR:   bypass_d   = jif.tdi;
            default: ;
        endcase
        if (state_q == TLR)
            ir_d = RESET_OP;
        else if (state_q == UPD_IR)
            ir_d = ir_shift_q;
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    always_comb begin
        idcode_d = idcode_q;
        if (state_q == CAP_DR)
            idcode_d = IDCODE_VAL;
        else if (state_q == SH_DR)
            idcode_d = {jif.tdi, idcode_q[31:1]};
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst)
            idcode_q <= '0;
        else
            idcode_q <= idcode_d;
    end

    assign idcode_lsb = idcode_q[0];
`else
    assign idcode_lsb = 1'b0;
`endif

    // TDO source mux; the pad copy is retimed to the falling edge below.
    always_comb begin
        tdo_pad_d   = 1'b0;
        tdo_padoe_d = (state_q == SH_DR) || (state_q == SH_IR);
        if (state_q == SH_IR)
            tdo_pad_d = ir_shift_q[0];
        else if (state_q == SH_DR) begin
            if (|chain_sel)
                tdo_pad_d = |(jif.chain_tdi_i & chain_sel);
            else if (idcode_sel)
                tdo_pad_d = idcode_lsb;
            else
                tdo_pad_d = bypass_q;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q    <= TLR;
            ir_q       <= RESET_OP;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
            tdo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
            tdo_q      <= tdo_d;
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo_pad_q   <= 1'b0;
            tdo_padoe_q <= 1'b0;
        end else begin
            tdo_pad_q   <= tdo_pad_d;
            tdo_padoe_q <= tdo_padoe_d;
        end
    end

    assign jif.tdo_pad_o      = tdo_pad_q;
    assign jif.tdo_padoe_o    = tdo_padoe_q;
    assign jif.tdo_o          = tdo_q;
    assign jif.chain_select_o = chain_sel;
    assign jif.shift_dr_o     = (state_q == SH_DR);
    assign jif.pause_dr_o     = (state_q == PAU_DR);
    assign jif.update_dr_o    = (state_q == UPD_DR);
    assign jif.capture_dr_o   = (state_q == CAP_DR);
    assign jif.tlr_o          = (state_q == TLR);

endmodule

// File: tb/tb_jtag_tap_ctrl_mc.sv
// Self-checking bench for jtag_tap_ctrl_mc: directed scans plus randomized data and tms walks,
// compared against a behavioural scan-result model (works with or without JTAG_IDCODE_EN).
module tb_jtag_tap_ctrl_mc;

    localparam logic [31:0] ID_VAL   = 32'h149511C3;
    localparam logic [3:0]  ID_OP    = 4'h1;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0]  RST_OP   = 4'h1;
`else
    localparam logic [3:0]  RST_OP   = 4'hF;
`endif

    logic tck;
    logic trst;
    int   compared   = 0;
    int   mismatched = 0;
    logic pad_before;
    logic pad_after_rise;

    jtag_tap_ctrl_mc_if #(.NUM_CHAINS(3)) jif ();

    jtag_tap_ctrl_mc dut (
        .tck  (tck),
        .trst (trst),
        .jif  (jif)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    // TAP transition table, states numbered TLR,RTI,SelDR,CapDR,ShDR,Ex1DR,PauDR,Ex2DR,UpdDR,
    // SelIR,CapIR,ShIR,Ex1IR,PauIR,Ex2IR,UpdIR.
    int next_on0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int next_on1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int chain_of(input logic [3:0] op);
        if (op == 4'hF) return -1;
`ifdef JTAG_IDCODE_EN
        if (op == ID_OP) return -1;
`endif
        if (op >= 4'd2 && op < 4'd5) return int'(op) - 2;
        return -1;
    endfunction

    function automatic logic [2:0] sel_of(input logic [3:0] op);
        int c = chain_of(op);
        return (c < 0) ? 3'b000 : 3'(1 << c);
    endfunction

    function automatic bit idcode_mode(input logic [3:0] op);
`ifdef JTAG_IDCODE_EN
        return op == ID_OP;
`else
        return 1'b0;
`endif
    endfunction

    // What a DR scan of n bits must return for a given active instruction.
    function automatic logic [63:0] expected_dr(input logic [3:0] op, input int n,
                                                input logic [63:0] din, input logic [63:0] src);
        logic [63:0] e = '0;
        int c = chain_of(op);
        for (int i = 0; i < n; i++) begin
            if (c >= 0)
                e[i] = src[i];
            else if (idcode_mode(op))
                e[i] = (i < 32) ? ID_VAL[i] : din[i-32];
            else
                e[i] = (i == 0) ? 1'b0 : din[i-1];
        end
        return e;
    endfunction

    function automatic logic [2:0] chain_drive(input int sel, input logic b);
        logic [2:0] v = 3'($urandom);
        if (sel >= 0) v[sel] = b;
        return v;
    endfunction

    // One tck cycle: drive before the rising edge, sample just after the falling edge.
    task automatic tick(input logic tms_v, input logic tdi_v, input logic [2:0] chain_v);
        jif.tms         = tms_v;
        jif.tdi         = tdi_v;
        jif.chain_tdi_i = chain_v;
        pad_before      = jif.tdo_pad_o;
        @(posedge tck);
        #1;
        pad_after_rise  = jif.tdo_pad_o;
        @(negedge tck);
        #1;
    endtask

    task automatic ir_scan(input logic [3:0] op);
        logic [3:0] cap;
        tick(1'b1, 1'b0, 3'($urandom));
        tick(1'b1, 1'b0, 3'($urandom));
        tick(1'b0, 1'b0, 3'($urandom));
        tick(1'b0, 1'b0, 3'($urandom));
        check("shir_padoe", jif.tdo_padoe_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cap[i] = jif.tdo_pad_o;
            tick(i == 3, op[i], 3'($urandom));
        end
        check("ir_capture", cap, 4'b0001);
        tick(1'b1, 1'b0, 3'($urandom));
        tick(1'b0, 1'b0, 3'($urandom));
        check("chain_select", jif.chain_select_o, sel_of(op));
    endtask

    // DR scan from RTI back to RTI; pause_at>0 detours through Pause-DR before that bit.
    task automatic dr_scan(input logic [3:0] op, input int n, input logic [63:0] din,
                           input logic [63:0] src, input int pause_at, input string tag);
        logic [63:0] dout = '0;
        int sel = chain_of(op);
        tick(1'b1, 1'b0, chain_drive(sel, src[0]));
        tick(1'b0, 1'b0, chain_drive(sel, src[0]));
        check("capture_dr", jif.capture_dr_o, 1'b1);
        tick(1'b0, 1'b0, chain_drive(sel, src[0]));
        check("shdr_entry", {jif.shift_dr_o, jif.tdo_padoe_o}, 2'b11);
        for (int i = 0; i < n; i++) begin
            dout[i] = jif.tdo_pad_o;
            if (i == pause_at - 1 && i != n - 1) begin
                tick(1'b1, din[i], chain_drive(sel, src[i+1]));
                check("tdo_o_delay", jif.tdo_o, din[i]);
                for (int p = 0; p < 5; p++) begin
                    tick(1'b0, 1'($urandom), chain_drive(sel, src[i+1]));
                    check("pause_flags", {jif.pause_dr_o, jif.tdo_padoe_o}, 2'b10);
                end
                tick(1'b1, 1'($urandom), chain_drive(sel, src[i+1]));
                tick(1'b0, 1'($urandom), chain_drive(sel, src[i+1]));
            end else begin
                tick(i == n - 1, din[i], chain_drive(sel, src[i+1]));
                check("tdo_o_delay", jif.tdo_o, din[i]);
                check("pad_hold_rise", pad_after_rise, pad_before);
            end
        end
        tick(1'b1, 1'b0, 3'($urandom));
        check("update_dr", jif.update_dr_o, 1'b1);
        tick(1'b0, 1'b0, 3'($urandom));
        check(tag, dout, expected_dr(op, n, din, src));
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] din;
        logic [63:0] src;
        int          n;
        int          st;
        logic        t;

        $display("[TB] start");
        trst            = 1'b0;
        jif.tms         = 1'b1;
        jif.tdi         = 1'b0;
        jif.chain_tdi_i = '0;
        repeat (2) @(negedge tck);
        #1;
        check("reset_outputs",
              {jif.tlr_o, jif.chain_select_o, jif.tdo_padoe_o, jif.tdo_pad_o, jif.tdo_o},
              {1'b1, 3'b000, 1'b0, 1'b0, 1'b0});
        trst = 1'b1;
        tick(1'b0, 1'b0, 3'b000);
        check("rti_after_reset", jif.tlr_o, 1'b0);

        // First scan after reset exercises the reset instruction.
        dr_scan(RST_OP, 40, {24'd0, 32'h0F0F_3C3C, 8'hA7}, 64'd0, 0, "reset_instr_scan");

        ir_scan(4'h3);
        dr_scan(4'h3, 8, 64'($urandom), 64'($urandom), 0, "chain1_scan");

        ir_scan(4'h4);
        dr_scan(4'h4, 8, 64'($urandom), 64'hA5, 0, "chain2_a5");

        ir_scan(4'hF);
        dr_scan(4'hF, 8, 64'b1011_0010, 64'($urandom), 0, "bypass_ff");
        ir_scan(4'hC);
        dr_scan(4'hC, 8, 64'b1011_0010, 64'($urandom), 0, "bypass_unused_c");

        ir_scan(ID_OP);
        dr_scan(ID_OP, 40, {32'($urandom), 32'($urandom)}, 64'd0, 0, "idcode_op_scan");

        for (int r = 0; r < 8; r++) begin
            op  = 4'($urandom);
            n   = 1 + int'($urandom_range(0, 39));
            din = {32'($urandom), 32'($urandom)};
            src = {32'($urandom), 32'($urandom)};
            ir_scan(op);
            dr_scan(op, n, din, src, (n > 12) ? 10 : 0, "random_scan");
        end

        // Asynchronous reset while shifting a selected chain.
        ir_scan(4'h4);
        tick(1'b1, 1'b0, 3'($urandom));
        tick(1'b0, 1'b0, 3'($urandom));
        tick(1'b0, 1'b0, 3'($urandom));
        tick(1'b0, 1'b1, 3'b111);
        trst = 1'b0;
        #2;
        check("trst_mid_shdr",
              {jif.tlr_o, jif.chain_select_o, jif.tdo_padoe_o, jif.tdo_pad_o, jif.tdo_o},
              {1'b1, 3'b000, 1'b0, 1'b0, 1'b0});
        @(negedge tck);
        #1;
        trst = 1'b1;
        tick(1'b0, 1'b0, 3'($urandom));
        dr_scan(RST_OP, 32, 64'($urandom), 64'd0, 0, "after_trst_32");
        dr_scan(RST_OP, 32, 64'($urandom), 64'd0, 10, "pause_hold_32");

        // Random tms walk against the transition table.
        st = 1;
        for (int w = 0; w < 120; w++) begin
            t = 1'($urandom);
            tick(t, 1'($urandom), 3'($urandom));
            st = t ? next_on1[st] : next_on0[st];
            check("walk_flags",
                  {jif.tlr_o, jif.capture_dr_o, jif.shift_dr_o, jif.pause_dr_o, jif.update_dr_o,
                   jif.tdo_padoe_o},
                  {st == 0, st == 3, st == 4, st == 6, st == 8, (st == 4 || st == 11)});
            if (st != 4 && st != 11)
                check("walk_pad_idle", jif.tdo_pad_o, 1'b0);
        end
        for (int f = 0; f < 5; f++)
            tick(1'b1, 1'b0, 3'($urandom));
        check("five_tms_tlr", jif.tlr_o, 1'b1);
        tick(1'b0, 1'b0, 3'($urandom));
        check("tlr_sync_select", jif.chain_select_o, sel_of(RST_OP));
        dr_scan(RST_OP, 40, {32'($urandom), 32'($urandom)}, 64'd0, 0, "after_tlr_scan");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
